// File: rtl/sm3_pad_stream.sv
// SM3 message padding unit: packs a byte-granular DW-bit message stream into
// 512-bit padded blocks and emits them as 32-bit words to the expansion stage.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   msg_inpt_d/_vld_byte/_vld/_lst message beat, byte-valid thermometer, last
//   msg_inpt_rdy                   beat accepted on vld & rdy
//   msg_abrt                       abort and flush current message
//   pad_otpt_ena                   downstream ready
//   pad_otpt_d/_vld/_lst           padded word, valid, last word of message
//   pad_otpt_abrt                  one-cycle flush pulse after an abort
//   msg_bit_len                    bits accepted so far in current message
//   pad_busy                       message in progress
module sm3_pad_stream #(
    parameter  int DW = 32,
    localparam int BW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] msg_inpt_d,
    input  logic [BW-1:0] msg_inpt_vld_byte,
    input  logic          msg_inpt_vld,
    input  logic          msg_inpt_lst,
    output logic          msg_inpt_rdy,
    input  logic          msg_abrt,
    input  logic          pad_otpt_ena,
    output logic [31:0]   pad_otpt_d,
    output logic          pad_otpt_vld,
    output logic          pad_otpt_lst,
    output logic          pad_otpt_abrt,
    output logic [63:0]   msg_bit_len,
    output logic          pad_busy
);

    localparam int WPB = DW / 32;

    typedef enum logic [1:0] {FILL, DRAIN, XPAD, DRAIN_FIN} state_e;

    state_e       state_q, state_d;
    logic [31:0]  buf_q [16];
    logic [31:0]  buf_d [16];
    logic [3:0]   ptr_q, ptr_d;
    logic [60:0]  cnt_q, cnt_d;
    logic         pend80_q, pend80_d;
    logic         padnx_q, padnx_d;
    logic         abrt_q;

    logic [3:0]   nlead;
    logic         zseen;
    logic [DW-1:0] beat;
    logic [4:0]   np;
    logic         full;
    logic [6:0]   fill;
    logic [60:0]  cnt_new;
    logic [63:0]  blen_new;

    always_comb begin
        // Leading-ones count of the byte-valid mask; bits after the first
        // zero do not count.
        nlead = '0;
        zseen = 1'b0;
        for (int k = 0; k < BW; k++) begin
            if (!zseen) begin
                if (msg_inpt_vld_byte[BW-1-k]) nlead = nlead + 4'd1;
                else zseen = 1'b1;
            end
        end
        beat = msg_inpt_d;
        if (msg_inpt_lst) begin
            for (int k = 0; k < BW; k++) begin
                if (4'(k) > nlead) beat[DW-1-8*k -: 8] = 8'h00;
                else if (4'(k) == nlead) beat[DW-1-8*k -: 8] = 8'h80;
            end
        end
        np       = {1'b0, ptr_q} + 5'(WPB);
        full     = np[4];
        // Bytes occupied in the block including the 0x80 marker.
        fill     = {1'b0, ptr_q, 2'b00} + 7'(nlead) + 7'd1;
        cnt_new  = cnt_q + (msg_inpt_lst ? 61'(nlead) : 61'(BW));
        blen_new = {cnt_new, 3'b000};
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        pend80_d = pend80_q;
        padnx_d  = padnx_q;
        unique case (state_q)
            FILL: begin
                if (msg_inpt_vld) begin
                    for (int j = 0; j < WPB; j++)
                        buf_d[ptr_q + 4'(j)] = beat[DW-1-32*j -: 32];
                    cnt_d = cnt_new;
                    ptr_d = np[3:0];
                    if (!msg_inpt_lst) begin
                        if (full) state_d = DRAIN;
                    end else begin
                        // Stale words from an earlier block must read zero.
                        for (int i = 0; i < 16; i++)
                            if (5'(i) >= np) buf_d[i] = '0;
                        // Full last beat: the marker goes in the next word.
                        if (nlead == 4'(BW) && !full)
                            buf_d[np[3:0]] = 32'h8000_0000;
                        ptr_d = '0;
                        if (nlead == 4'(BW) && full) begin
                            state_d  = DRAIN;
                            pend80_d = 1'b1;
                        end else if (fill <= 7'd56) begin
                            buf_d[14] = blen_new[63:32];
                            buf_d[15] = blen_new[31:0];
                            state_d   = DRAIN_FIN;
                        end else begin
                            state_d = DRAIN;
                            padnx_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN, DRAIN_FIN: begin
                if (pad_otpt_ena) begin
                    ptr_d = ptr_q + 4'd1;
                    if (ptr_q == 4'd15) begin
                        if (state_q == DRAIN) begin
                            state_d = (pend80_q || padnx_q) ? XPAD : FILL;
                        end else begin
                            state_d  = FILL;
                            cnt_d    = '0;
                            pend80_d = 1'b0;
                            padnx_d  = 1'b0;
                        end
                    end
                end
            end
            XPAD: begin
                for (int i = 0; i < 16; i++) buf_d[i] = '0;
                if (pend80_q) buf_d[0] = 32'h8000_0000;
                buf_d[14] = msg_bit_len[63:32];
                buf_d[15] = msg_bit_len[31:0];
                state_d   = DRAIN_FIN;
            end
            default: state_d = FILL;
        endcase
        if (msg_abrt) begin
            state_d  = FILL;
            for (int i = 0; i < 16; i++) buf_d[i] = '0;
            ptr_d    = '0;
            cnt_d    = '0;
            pend80_d = 1'b0;
            padnx_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            for (int i = 0; i < 16; i++) buf_q[i] <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            pend80_q <= 1'b0;
            padnx_q  <= 1'b0;
            abrt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            pend80_q <= pend80_d;
            padnx_q  <= padnx_d;
            abrt_q   <= msg_abrt;
        end
    end

    assign msg_inpt_rdy  = (state_q == FILL);
    assign pad_otpt_vld  = (state_q == DRAIN) || (state_q == DRAIN_FIN);
    assign pad_otpt_d    = pad_otpt_vld ? buf_q[ptr_q] : 32'h0;
    assign pad_otpt_lst  = (state_q == DRAIN_FIN) && (ptr_q == 4'd15) && !msg_abrt;
    assign pad_otpt_abrt = abrt_q;
    assign msg_bit_len   = {cnt_q, 3'b000};
    assign pad_busy      = (state_q != FILL) || (cnt_q != 61'd0);

endmodule
